// File: rtl/cpu_mem_loader.sv
// Host-side loader for the cpu external memory ports: streams imem/dmem images in,
// runs the cpu for a set cycle count, then streams dmem back out when LOADER_DUMP_EN is defined.
module cpu_mem_loader #(
  parameter int IMEM_ADDR_W = 9,
  parameter int DMEM_ADDR_W = 10
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic                   start,
  input  logic [IMEM_ADDR_W:0]   imem_len,
  input  logic [DMEM_ADDR_W:0]   dmem_len,
  input  logic [31:0]            run_cycles,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [31:0]            s_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [31:0]            m_data,
  output logic                   busy,
  output logic                   done,
  output logic                   cpu_enable,
  output logic [63:0]            addr_ext,
  output logic                   wen_ext,
  output logic [31:0]            wdata_ext,
  output logic [63:0]            addr_ext_2,
  output logic                   wen_ext_2,
  output logic                   ren_ext_2,
  output logic [63:0]            wdata_ext_2,
  input  logic [63:0]            rdata_ext_2
);
  localparam int IW = IMEM_ADDR_W;
  localparam int DW = DMEM_ADDR_W;

  typedef enum logic [2:0] {S_IDLE, S_LOAD_I, S_LOAD_D, S_RUN, S_DUMP} state_t;
  state_t state, state_nx;

  logic [IW:0] len_i, cnt_i;
  logic [DW:0] len_d, cnt_d;
  logic [31:0] run_left;
  logic [31:0] lo_half_p0;
  logic        hi_beat;
  logic        beat;

  function automatic logic [IW:0] sat_len_i(input logic [IW:0] l);
    sat_len_i = (l[IW] && (|l[IW-1:0])) ? {1'b1, {IW{1'b0}}} : l;
  endfunction

  function automatic logic [DW:0] sat_len_d(input logic [DW:0] l);
    sat_len_d = (l[DW] && (|l[DW-1:0])) ? {1'b1, {DW{1'b0}}} : l;
  endfunction

  function automatic logic [63:0] imem_byte_addr(input logic [IW-1:0] c);
    imem_byte_addr = {{(62-IW){1'b0}}, c, 2'b00};
  endfunction

  function automatic logic [63:0] dmem_byte_addr(input logic [DW-1:0] c);
    dmem_byte_addr = {{(61-DW){1'b0}}, c, 3'b000};
  endfunction

  assign beat = s_valid & s_ready;

`ifdef LOADER_DUMP_EN
  // Per-word dump phases: issue read, memory latency, capture, low beat, high beat.
  typedef enum logic [2:0] {D_ISSUE, D_READ, D_CAPT, D_LO, D_HI} dph_t;
  dph_t        dph;
  logic [63:0] rd_word_p1;
  logic        last_word;

  assign last_word = ((cnt_d + {{DW{1'b0}}, 1'b1}) == len_d);
  assign m_valid   = (state == S_DUMP) && ((dph == D_LO) || (dph == D_HI));
  assign m_data    = !m_valid ? 32'd0 : (dph == D_HI) ? rd_word_p1[63:32] : rd_word_p1[31:0];
`else
  logic unused_dump;
  assign unused_dump = m_ready ^ (^rdata_ext_2);
  assign m_valid     = 1'b0;
  assign m_data      = 32'd0;
  assign ren_ext_2   = 1'b0;
`endif

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start) state_nx = S_LOAD_I;
      S_LOAD_I: if (cnt_i == len_i) state_nx = S_LOAD_D;
      S_LOAD_D: if (cnt_d == len_d) state_nx = S_RUN;
      S_RUN: begin
        if (run_left == 32'd0) begin
`ifdef LOADER_DUMP_EN
          state_nx = (len_d == '0) ? S_IDLE : S_DUMP;
`else
          state_nx = S_IDLE;
`endif
        end
      end
      S_DUMP: begin
`ifdef LOADER_DUMP_EN
        if ((dph == D_HI) && m_ready && last_word) state_nx = S_IDLE;
`else
        state_nx = S_IDLE;
`endif
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != S_IDLE);
    s_ready    = 1'b0;
    cpu_enable = 1'b0;
    case (state)
      S_LOAD_I: s_ready    = (cnt_i != len_i);
      S_LOAD_D: s_ready    = (cnt_d != len_d);
      S_RUN:    cpu_enable = (run_left != 32'd0);
      default:  ;
    endcase
  end

  // Memory strobes are registered one cycle behind the accepting handshake.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      len_i       <= '0;
      len_d       <= '0;
      cnt_i       <= '0;
      cnt_d       <= '0;
      run_left    <= '0;
      lo_half_p0  <= '0;
      hi_beat     <= 1'b0;
      done        <= 1'b0;
      wen_ext     <= 1'b0;
      addr_ext    <= '0;
      wdata_ext   <= '0;
      wen_ext_2   <= 1'b0;
      addr_ext_2  <= '0;
      wdata_ext_2 <= '0;
`ifdef LOADER_DUMP_EN
      ren_ext_2   <= 1'b0;
      dph         <= D_ISSUE;
      rd_word_p1  <= '0;
`endif
    end else begin
      wen_ext   <= 1'b0;
      wen_ext_2 <= 1'b0;
`ifdef LOADER_DUMP_EN
      ren_ext_2 <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (start) begin
            len_i    <= sat_len_i(imem_len);
            len_d    <= sat_len_d(dmem_len);
            run_left <= run_cycles;
            cnt_i    <= '0;
            cnt_d    <= '0;
            hi_beat  <= 1'b0;
            done     <= 1'b0;
          end
        end
        S_LOAD_I: begin
          if (beat) begin
            wen_ext   <= 1'b1;
            addr_ext  <= imem_byte_addr(cnt_i[IW-1:0]);
            wdata_ext <= s_data;
            cnt_i     <= cnt_i + {{IW{1'b0}}, 1'b1};
          end
        end
        S_LOAD_D: begin
          if (beat) begin
            hi_beat <= ~hi_beat;
            if (!hi_beat) begin
              lo_half_p0 <= s_data;
            end else begin
              wen_ext_2   <= 1'b1;
              addr_ext_2  <= dmem_byte_addr(cnt_d[DW-1:0]);
              wdata_ext_2 <= {s_data, lo_half_p0};
              cnt_d       <= cnt_d + {{DW{1'b0}}, 1'b1};
            end
          end
        end
        S_RUN: begin
          if (run_left != 32'd0) run_left <= run_left - 32'd1;
          cnt_d <= '0;
`ifdef LOADER_DUMP_EN
          dph   <= D_ISSUE;
`endif
        end
        S_DUMP: begin
`ifdef LOADER_DUMP_EN
          case (dph)
            D_ISSUE: begin
              ren_ext_2  <= 1'b1;
              addr_ext_2 <= dmem_byte_addr(cnt_d[DW-1:0]);
              dph        <= D_READ;
            end
            D_READ:  dph <= D_CAPT;
            D_CAPT: begin
              rd_word_p1 <= rdata_ext_2;
              dph        <= D_LO;
            end
            D_LO:    if (m_ready) dph <= D_HI;
            D_HI: begin
              if (m_ready) begin
                cnt_d <= cnt_d + {{DW{1'b0}}, 1'b1};
                dph   <= D_ISSUE;
              end
            end
            default: dph <= D_ISSUE;
          endcase
`endif
        end
        default: ;
      endcase
      if ((state != S_IDLE) && (state_nx == S_IDLE)) done <= 1'b1;
    end
  end
endmodule

// File: tb/tb_cpu_mem_loader.sv
// Directed bench for cpu_mem_loader: vector table of full load/run/dump sequences plus
// hand-written reset, busy-start and dump back-pressure sequences.
module tb_cpu_mem_loader;
  localparam int IW = 9;
  localparam int DW = 10;
`ifdef LOADER_DUMP_EN
  localparam bit DUMP_ON = 1'b1;
`else
  localparam bit DUMP_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          arst_n = 1'b1;
  logic          start = 1'b0;
  logic [IW:0]   imem_len = '0;
  logic [DW:0]   dmem_len = '0;
  logic [31:0]   run_cycles = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [31:0]   s_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [31:0]   m_data;
  logic          busy, done, cpu_enable;
  logic [63:0]   addr_ext, addr_ext_2, wdata_ext_2;
  logic [63:0]   rdata_ext_2 = '0;
  logic          wen_ext, wen_ext_2, ren_ext_2;
  logic [31:0]   wdata_ext;

  always #5 clk = ~clk;

  cpu_mem_loader #(.IMEM_ADDR_W(IW), .DMEM_ADDR_W(DW)) dut (
    .clk(clk), .arst_n(arst_n), .start(start), .imem_len(imem_len), .dmem_len(dmem_len),
    .run_cycles(run_cycles), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .busy(busy), .done(done),
    .cpu_enable(cpu_enable), .addr_ext(addr_ext), .wen_ext(wen_ext), .wdata_ext(wdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
    .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for handshake", name);
  endtask

  // Data memory model: registered read, data valid the cycle after ren_ext_2.
  logic [63:0] tb_dmem [0:(1<<DW)-1];
  always @(posedge clk) begin
    if (wen_ext_2) tb_dmem[addr_ext_2[DW+2:3]] <= wdata_ext_2;
    if (ren_ext_2) rdata_ext_2 <= tb_dmem[addr_ext_2[DW+2:3]];
  end

  int          en_cyc = 0, en_rise = 0, conflicts = 0;
  logic        en_prev = 1'b0;
  logic [63:0] iw_addr[$], dw_addr[$], dw_data[$];
  logic [31:0] iw_data[$], dump_q[$];
  always @(negedge clk) begin
    if (cpu_enable) en_cyc++;
    if (cpu_enable && !en_prev) en_rise++;
    en_prev = cpu_enable;
    if (wen_ext) begin iw_addr.push_back(addr_ext); iw_data.push_back(wdata_ext); end
    if (wen_ext_2) begin dw_addr.push_back(addr_ext_2); dw_data.push_back(wdata_ext_2); end
    if (wen_ext_2 && ren_ext_2) conflicts++;
    if (m_valid && m_ready) dump_q.push_back(m_data);
  end

  function automatic logic [31:0] iword(input int k);
    case (k)
      0: iword = 32'h0000_0013;
      1: iword = 32'h0010_0093;
      2: iword = 32'h0020_8113;
      default: iword = 32'hA500_0000 | 32'(k);
    endcase
  endfunction

  function automatic logic [31:0] dbeat(input int k);
    dbeat = (k < 4) ? 32'(k + 1) : (32'h5A00_0000 | 32'(k));
  endfunction

  logic [31:0] beats[$];

  // All tasks start and end 1 time unit after a rising edge.
  task automatic pulse_start(input int il, input int dl, input int rc);
    imem_len = il[IW:0];
    dmem_len = dl[DW:0];
    run_cycles = rc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_beats(input string name);
    foreach (beats[k]) begin
      int t;
      t = 0;
      s_valid = 1'b1;
      s_data = beats[k];
      while (!s_ready && t < 200) begin @(posedge clk); #1; t++; end
      if (!s_ready) begin
        fail_timeout(name);
        s_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (busy && t < 5000) begin @(posedge clk); #1; t++; end
    if (busy) fail_timeout({name, " done"});
  endtask

  typedef struct {
    int il, dl, rc;
    int exp_iw, exp_dw, exp_en, exp_rise, exp_db;
  } vec_t;

  task automatic do_vec(input vec_t v, input string tag);
    int bi, bd, be, br, bq, mism;
    bi = iw_addr.size(); bd = dw_addr.size(); be = en_cyc; br = en_rise; bq = dump_q.size();
    pulse_start(v.il, v.dl, v.rc);
    check({tag, " done_clr"}, 64'(done), 64'd0);
    check({tag, " busy"}, 64'(busy), 64'd1);
    beats.delete();
    for (int k = 0; k < v.exp_iw; k++) beats.push_back(iword(k));
    send_beats({tag, " imem"});
    if (v.exp_iw > 0) check({tag, " s_ready_drop_i"}, 64'(s_ready), 64'd0);
    beats.delete();
    for (int k = 0; k < 2 * v.exp_dw; k++) beats.push_back(dbeat(k));
    send_beats({tag, " dmem"});
    if (v.exp_dw > 0) check({tag, " s_ready_drop_d"}, 64'(s_ready), 64'd0);
    wait_done(tag);
    repeat (2) @(posedge clk);
    #1;
    check({tag, " done"}, 64'(done), 64'd1);
    check({tag, " busy_end"}, 64'(busy), 64'd0);
    check({tag, " imem_writes"}, 64'(iw_addr.size() - bi), 64'(v.exp_iw));
    check({tag, " dmem_writes"}, 64'(dw_addr.size() - bd), 64'(v.exp_dw));
    check({tag, " en_cycles"}, 64'(en_cyc - be), 64'(v.exp_en));
    check({tag, " en_runs"}, 64'(en_rise - br), 64'(v.exp_rise));
    check({tag, " dump_beats"}, 64'(dump_q.size() - bq), 64'(v.exp_db));
    mism = 0;
    for (int k = 0; k < v.exp_iw && bi + k < iw_addr.size(); k++)
      if (iw_addr[bi+k] != 64'(k * 4) || iw_data[bi+k] != iword(k)) mism++;
    check({tag, " imem_content"}, 64'(mism), 64'd0);
    mism = 0;
    for (int k = 0; k < v.exp_dw && bd + k < dw_addr.size(); k++)
      if (dw_addr[bd+k] != 64'(k * 8) || dw_data[bd+k] != {dbeat(2*k+1), dbeat(2*k)}) mism++;
    check({tag, " dmem_content"}, 64'(mism), 64'd0);
    mism = 0;
    for (int k = 0; k < v.exp_db && bq + k < dump_q.size(); k++)
      if (dump_q[bq+k] != dbeat(k)) mism++;
    check({tag, " dump_content"}, 64'(mism), 64'd0);
  endtask

  vec_t vecs[5];

  initial begin
    int bi, bd, be, bq, t;
    vecs[0] = '{3, 2, 5, 3, 2, 5, 1, DUMP_ON ? 4 : 0};
    vecs[1] = '{1, 1, 1, 1, 1, 1, 1, DUMP_ON ? 2 : 0};
    vecs[2] = '{0, 0, 0, 0, 0, 0, 0, 0};
    vecs[3] = '{4, 3, 0, 4, 3, 0, 0, DUMP_ON ? 6 : 0};
    vecs[4] = '{1023, 1, 2, 512, 1, 2, 1, DUMP_ON ? 2 : 0};

    #2 arst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst strobes", 64'({s_ready, m_valid, cpu_enable, wen_ext, wen_ext_2, ren_ext_2}), 64'd0);
    check("rst addr", addr_ext | addr_ext_2, 64'd0);
    check("rst data", wdata_ext_2 | 64'(wdata_ext) | 64'(m_data), 64'd0);
    arst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 5; v++) do_vec(vecs[v], $sformatf("vec%0d", v));

    // Asynchronous reset in LOAD_D right after a dmem write was launched.
    pulse_start(1, 2, 3);
    beats.delete(); beats.push_back(iword(0));
    send_beats("rst imem");
    beats.delete(); beats.push_back(32'h11); beats.push_back(32'h22);
    send_beats("rst dmem");
    check("rst_mid wen_pre", 64'(wen_ext_2), 64'd1);
    #2 arst_n = 1'b0;
    #1;
    check("rst_mid wen_ext_2", 64'(wen_ext_2), 64'd0);
    check("rst_mid busy", 64'(busy), 64'd0);
    check("rst_mid s_ready", 64'(s_ready), 64'd0);
    check("rst_mid done", 64'(done), 64'd0);
    @(posedge clk); #1;
    arst_n = 1'b1;
    do_vec('{1, 1, 1, 1, 1, 1, 1, DUMP_ON ? 2 : 0}, "reload");

    // Zero-length images with start re-asserted while busy.
    bi = iw_addr.size(); bd = dw_addr.size(); be = en_cyc;
    pulse_start(0, 0, 3);
    imem_len = 10'd2; dmem_len = 11'd1; run_cycles = 32'd9; start = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    start = 1'b0;
    wait_done("busy_start");
    check("busy_start done", 64'(done), 64'd1);
    check("busy_start en_cycles", 64'(en_cyc - be), 64'd3);
    check("busy_start writes", 64'((iw_addr.size() - bi) + (dw_addr.size() - bd)), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("busy_start idle", 64'(busy), 64'd0);

`ifdef LOADER_DUMP_EN
    // Dump back-pressure: m_ready low for 3 cycles on the first beat.
    m_ready = 1'b0;
    bq = dump_q.size();
    pulse_start(0, 1, 0);
    beats.delete(); beats.push_back(32'hCAFE_F00D); beats.push_back(32'hDEAD_BEEF);
    send_beats("stall dmem");
    t = 0;
    while (!m_valid && t < 100) begin @(posedge clk); #1; t++; end
    if (!m_valid) fail_timeout("stall m_valid");
    check("stall lo_data", 64'(m_data), 64'hCAFE_F00D);
    repeat (3) begin
      @(posedge clk); #1;
      check("stall hold_valid", 64'(m_valid), 64'd1);
      check("stall hold_data", 64'(m_data), 64'hCAFE_F00D);
    end
    m_ready = 1'b1;
    @(posedge clk); #1;
    check("stall hi_valid", 64'(m_valid), 64'd1);
    check("stall hi_data", 64'(m_data), 64'hDEAD_BEEF);
    wait_done("stall");
    check("stall beats", 64'(dump_q.size() - bq), 64'd2);
    check("stall beat0", 64'(dump_q.size() > bq ? dump_q[bq] : 32'd0), 64'hCAFE_F00D);
    check("stall beat1", 64'(dump_q.size() > bq + 1 ? dump_q[bq+1] : 32'd0), 64'hDEAD_BEEF);
`endif

    check("port conflicts", 64'(conflicts), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
